saturn_debug_uart_tx: RTL
=========================

// Module: saturn_debug_uart_tx
// PURPOSE
//  Consumes the character stream produced by the Saturn debugger and serialises it onto a UART TX line (8N1).
//  Characters are buffered in a FIFO and sent back-to-back. A full register dump can be queued while the line drains.
//  Sits between the debugger's char output and the board's TX pin.
// PARAMETERS
//  CLK_DIV          104  i_clk cycles per UART bit; legal range >= 2
//  FIFO_DEPTH_LOG2  4    log2 of FIFO depth; default depth is 16 entries
// PORTS
//  i_clk         in   1  system clock
//  i_reset       in   1  synchronous, active-high reset
//  i_char        in   8  character to transmit
//  i_char_valid  in   1  i_char is valid this cycle
//  o_char_ready  out  1  FIFO can accept a char this cycle (= !full)
//  o_overflow    out  1  sticky: a valid char was offered while full
//  o_busy        out  1  FIFO not empty, or FSM not in IDLE
//  o_tx          out  1  serial output; idle high
// BEHAVIOUR
//  Reset: all outputs are registered or derived from registered state; i_reset has priority over everything.
//   - o_tx=1, o_overflow=0, o_busy=0, o_char_ready=1.
//   - FIFO pointers and count are 0; FSM is IDLE; bit and baud counters are 0.
//  FIFO storage:
//   - count is FIFO_DEPTH_LOG2+1 bits; rd/wr pointers wrap modulo depth.
//   - full when count==depth; empty when count==0.
//  Push: at an edge where i_char_valid && o_char_ready, i_char is written at wr_ptr and wr_ptr increments.
//  Overflow:
//   - At an edge where i_char_valid && !o_char_ready, the char is dropped and o_overflow<=1.
//   - o_overflow clears only on reset.
//  Pop: occurs only when the FSM takes a char (see below).
//   - Push and pop in the same edge: count is unchanged, both pointers advance.
//   - o_char_ready reflects count before that edge, so a full FIFO rejects even while popping.
//  FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLK_DIV-1 in each bit slot.
//   - IDLE: o_tx=1. If FIFO non-empty:
//       pop into shift reg; o_tx<=0; baud<=0; go to START.
//   - START: hold o_tx=0 for CLK_DIV cycles. Then o_tx<=shift[0]; bit<=0; go to DATA.
//   - DATA: each bit is held CLK_DIV cycles, LSB first.
//       bit<7: shift right; o_tx<=next bit; bit++.
//       bit==7: o_tx<=1; go to STOP.
//   - STOP: hold o_tx=1 for CLK_DIV cycles. Then:
//       FIFO non-empty: pop; o_tx<=0; go to START (no idle gap).
//       FIFO empty: go to IDLE.
//  Timing:
//   - A frame is exactly 10*CLK_DIV cycles.
//   - A char accepted at edge E while IDLE and empty drives o_tx low from edge E+1 (1-cycle latency).
//  Reset mid-frame: o_tx=1 from the reset edge. Queued chars are discarded and the partial frame is not resumed.
//  i_char is sampled only on accept; it may change freely otherwise.
// TESTING
//  1. CLK_DIV=4, push 0x55 once.
//     -> o_tx low 1 cycle after accept; slots 0,1,0,1,0,1,0,1,0,1 of 4 cycles each; o_busy falls after 40 cycles.
//  2. Push "P","C" on consecutive cycles.
//     -> two contiguous frames (80 cycles, no idle high gap); bytes decode to 0x50, 0x43.
//  3. CLK_DIV=4, depth 16. Push 1 char; after it enters START, push 17 chars on consecutive cycles.
//     -> 16 accepted; o_char_ready=0 on the 17th; o_overflow=1; exactly 17 frames sent in order.
//  4. Assert i_reset at bit 3 of a frame with 5 chars queued.
//     -> o_tx=1, o_busy=0, o_overflow=0 next cycle; no further frames.
//  5. Push 40 chars 0x00..0x27 in bursts of 10 with gaps.
//     -> pointers wrap; all 40 received in order; o_overflow stays 0.
//  6. FIFO full, then a push coincides with the STOP->START pop.
//     -> push rejected; count becomes depth-1; o_overflow=1.

Source files
------------

// File: rtl/saturn_debug_uart_tx.sv
// saturn_debug_uart_tx: FIFO-buffered 8N1 UART transmitter for the Saturn debugger character stream.
module saturn_debug_uart_tx #(
  parameter int CLK_DIV = 104,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_char,
  input  logic       i_char_valid,
  output logic       o_char_ready,
  output logic       o_overflow,
  output logic       o_busy,
  output logic       o_tx
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int BW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0] count;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_idx, bit_n;
  logic [7:0] shift, shift_n;
  logic tx_n, push, pop, empty, baud_end;
  assign empty = count == '0;
  assign o_char_ready = count != (FIFO_DEPTH_LOG2+1)'(DEPTH);
  assign push = i_char_valid && o_char_ready;
  assign baud_end = baud == BW'(CLK_DIV - 1);
  assign o_busy = !empty || state != IDLE;
  always_comb begin
    state_n = state;
    baud_n = baud_end ? '0 : baud + 1'b1;
    bit_n = bit_idx;
    shift_n = shift;
    tx_n = o_tx;
    pop = 1'b0;
    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n = 1'b1;
        if (!empty) begin
          pop = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n = 1'b0;
          state_n = START;
        end
      end
      START: if (baud_end) begin
        tx_n = shift[0];
        bit_n = '0;
        state_n = DATA;
      end
      DATA: if (baud_end) begin
        if (bit_idx != 3'd7) begin
          shift_n = shift >> 1;
          tx_n = shift[1];
          bit_n = bit_idx + 1'b1;
        end else begin
          tx_n = 1'b1;
          state_n = STOP;
        end
      end
      STOP: if (baud_end) begin
        // chain straight into the next start bit so queued chars leave no idle gap
        if (!empty) begin
          pop = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n = 1'b0;
          state_n = START;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      o_tx <= 1'b1;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_idx <= bit_n;
      shift <= shift_n;
      o_tx <= tx_n;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{FIFO_DEPTH_LOG2{1'b0}}, push} - {{FIFO_DEPTH_LOG2{1'b0}}, pop};
      if (i_char_valid && !o_char_ready) o_overflow <= 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (push && !i_reset) mem[wr_ptr] <= i_char;
  end
endmodule
